lowampa_thresh_sequencer: RTL and testbench

Loads per-beam trigger thresholds into the cascaded chain of dual low-amplitude beam modules. Host writes land in a local buffer of 2×NBEAMS 18-bit thresholds. A commit request makes the block shift the buffer out through the cascade with per-lane write strobes, then fire a single simultaneous update so every beam switches thresholds on the same clock. It sits between the register interface and the first beam module's `thresh_i`/`thresh_wr_i`/`thresh_update_i`, which fan out to the whole cascade.

---
 rtl/lowampa_thresh_pkg.sv | 20 ++
 rtl/lowampa_thresh_sequencer_if.sv | 29 ++
 rtl/lowampa_thresh_buffer.sv | 34 +++
 rtl/lowampa_thresh_sequencer.sv | 136 +++++++++++++
 tb/tb_lowampa_thresh_sequencer.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/lowampa_thresh_pkg.sv
// Shared types and constants for the low-amplitude beam threshold sequencer.
// Threshold width, lane indices and the load FSM state encoding.
package lowampa_thresh_pkg;

    localparam int THRESH_BITS = 18;
    localparam int LANE_A      = 0;
    localparam int LANE_B      = 1;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        WAIT,
        UPDATE,
        DONE
    } thr_seq_state_t;

    // One buffer entry: both lanes of a beam, indexed by LANE_A / LANE_B.
    typedef logic [1:0][THRESH_BITS-1:0] thr_pair_t;

endpackage

// File: rtl/lowampa_thresh_sequencer_if.sv
// Host-side register port and cascade-head port of the threshold sequencer.
// slave = sequencer side, master = host / cascade-model side.
interface lowampa_thresh_sequencer_if
    import lowampa_thresh_pkg::*;
#(
    parameter int NBEAMS = 24
);
    logic                            thr_wr_i;
    logic [$clog2(2*NBEAMS)-1:0]     thr_addr_i;
    logic [THRESH_BITS-1:0]          thr_dat_i;
    logic                            commit_i;
    logic [1:0]                      commit_mask_i;
    logic [2*THRESH_BITS-1:0]        thresh_o;
    logic [1:0]                      thresh_wr_o;
    logic [1:0]                      thresh_update_o;
    logic                            busy_o;
    logic                            done_o;
    logic                            err_o;

    modport slave (
        input  thr_wr_i, thr_addr_i, thr_dat_i, commit_i, commit_mask_i,
        output thresh_o, thresh_wr_o, thresh_update_o, busy_o, done_o, err_o
    );

    modport master (
        output thr_wr_i, thr_addr_i, thr_dat_i, commit_i, commit_mask_i,
        input  thresh_o, thresh_wr_o, thresh_update_o, busy_o, done_o, err_o
    );
endinterface

// File: rtl/lowampa_thresh_buffer.sv
// Threshold staging buffer: per-lane writes, one beam (both lanes) read per cycle.
// Registered read, one cycle latency; contents survive reset.
module lowampa_thresh_buffer
    import lowampa_thresh_pkg::*;
#(
    parameter int NBEAMS = 24,
    parameter int AW     = $clog2(2*NBEAMS),
    parameter int IW     = $clog2(NBEAMS)
) (
    input  logic                   clk,
    input  logic                   wrEn,
    input  logic [AW-1:0]          wrAddr,
    input  logic [THRESH_BITS-1:0] wrDat,
    input  logic                   rdEn,
    input  logic [IW-1:0]          rdIdx,
    output thr_pair_t              rdDat
);

    thr_pair_t       mem [NBEAMS];
    logic [IW-1:0]   wrBeam;

    assign wrBeam = wrAddr[AW-1:1];

    // Addresses past the last beam exist when NBEAMS is not a power of two.
    always_ff @(posedge clk) begin
        if (wrEn && (int'(wrBeam) < NBEAMS)) begin
            mem[wrBeam][wrAddr[0]] <= wrDat;
        end
        if (rdEn) begin
            rdDat <= mem[rdIdx];
        end
    end

endmodule

// File: rtl/lowampa_thresh_sequencer.sv
// Shifts buffered per-beam thresholds into the beam cascade, then fires one update.
// Commit to first strobe 2 cycles; commits while busy queue one deep, writes while busy drop.
module lowampa_thresh_sequencer
    import lowampa_thresh_pkg::*;
#(
    parameter int NBEAMS     = 24,
    parameter int UPDATE_DLY = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    lowampa_thresh_sequencer_if.slave bus
);

    localparam int IW = $clog2(NBEAMS);
    localparam int AW = $clog2(2*NBEAMS);
    localparam int CW = $clog2(UPDATE_DLY + 2);
    localparam logic [IW-1:0] LAST_IDX = IW'(NBEAMS - 1);
    localparam logic [CW-1:0] DLY_LAST = CW'(UPDATE_DLY);

    thr_seq_state_t state;
    logic [1:0]     loadMask;
    logic [1:0]     pendMask;
    logic           pend;
    logic [IW-1:0]  idx;
    logic [CW-1:0]  dlyCnt;
    logic [1:0]     wrStb;
    logic [1:0]     updStb;
    logic           busy;
    logic           done;
    logic           err;
    thr_pair_t      rdDat;

    logic           idle;
    logic           hostWr;
    logic           startReq;
    logic [1:0]     startMask;

    assign idle      = (state == IDLE);
    assign hostWr    = bus.thr_wr_i && idle;
    assign startReq  = bus.commit_i || pend;
    // A fresh commit arriving in the IDLE slot supersedes the queued one.
    assign startMask = bus.commit_i ? bus.commit_mask_i : pendMask;

    lowampa_thresh_buffer #(
        .NBEAMS (NBEAMS),
        .AW     (AW),
        .IW     (IW)
    ) u_buf (
        .clk    (clk_i),
        .wrEn   (hostWr),
        .wrAddr (bus.thr_addr_i),
        .wrDat  (bus.thr_dat_i),
        .rdEn   (state == LOAD),
        .rdIdx  (idx),
        .rdDat  (rdDat)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state    <= IDLE;
            loadMask <= '0;
            pendMask <= '0;
            pend     <= 1'b0;
            idx      <= '0;
            dlyCnt   <= '0;
            wrStb    <= '0;
            updStb   <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            // Strobe lines up with the registered buffer read issued this cycle.
            wrStb  <= (state == LOAD) ? loadMask : 2'b00;
            updStb <= '0;
            done   <= 1'b0;

            if (bus.thr_wr_i && !idle) begin
                err <= 1'b1;
            end
            if (bus.commit_i && !idle) begin
                pend     <= 1'b1;
                pendMask <= bus.commit_mask_i;
            end

            case (state)
                IDLE: begin
                    if (startReq) begin
                        pend <= 1'b0;
                        err  <= 1'b0;
                        busy <= 1'b1;
                        if (startMask != 2'b00) begin
                            loadMask <= startMask;
                            idx      <= LAST_IDX;
                            state    <= LOAD;
                        end else begin
                            done  <= 1'b1;
                            state <= DONE;
                        end
                    end
                end
                LOAD: begin
                    idx <= idx - 1'b1;
                    if (idx == '0) begin
                        dlyCnt <= '0;
                        state  <= WAIT;
                    end
                end
                WAIT: begin
                    if (dlyCnt == DLY_LAST) begin
                        updStb <= loadMask;
                        state  <= UPDATE;
                    end else begin
                        dlyCnt <= dlyCnt + 1'b1;
                    end
                end
                UPDATE: begin
                    done  <= 1'b1;
                    state <= DONE;
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.thresh_o        = (wrStb != 2'b00) ? {rdDat[LANE_B], rdDat[LANE_A]} : '0;
    assign bus.thresh_wr_o     = wrStb;
    assign bus.thresh_update_o = updStb;
    assign bus.busy_o          = busy;
    assign bus.done_o          = done;
    assign bus.err_o           = err;

endmodule

// File: tb/tb_lowampa_thresh_sequencer.sv
// Bench for lowampa_thresh_sequencer: table-driven commit scenarios plus hand-written
// sequences for write-while-busy, commit-during-load and reset mid-load.
module tb_lowampa_thresh_sequencer;
    import lowampa_thresh_pkg::*;

    localparam int N  = 4;
    localparam int D  = 2;
    localparam int AW = $clog2(2*N);

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    lowampa_thresh_sequencer_if #(.NBEAMS(N)) bus ();

    lowampa_thresh_sequencer #(.NBEAMS(N), .UPDATE_DLY(D)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    int nChecks = 0;
    int nPass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nChecks++;
        if (act === exp) nPass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // Bench's own record of what the buffer should hold.
    logic [17:0] shA [N];
    logic [17:0] shB [N];

    typedef struct packed {
        logic [1:0]  wr;
        logic [35:0] dat;
    } sb_t;
    sb_t sbq [$];
    sb_t monE;

    task automatic pushLoad(input logic [1:0] m);
        if (m != 2'b00)
            for (int b = N - 1; b >= 0; b--) sbq.push_back({m, shB[b], shA[b]});
    endtask

    // Cascade model: head is module 0, shifts toward module N-1, update copies to active.
    logic [17:0] casA [N];
    logic [17:0] casB [N];
    logic [17:0] actA [N];
    logic [17:0] actB [N];
    logic [17:0] expActA [N];
    logic [17:0] expActB [N];

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.thresh_wr_o != 2'b00) begin
                if (sbq.size() == 0) begin
                    check("unexpected_wr", {36'd0, bus.thresh_wr_o}, 64'd0);
                end else begin
                    monE = sbq.pop_front();
                    check("cascade_word", {bus.thresh_wr_o, bus.thresh_o}, {monE.wr, monE.dat});
                end
                if (bus.thresh_wr_o[0]) begin
                    for (int i = N - 1; i > 0; i--) casA[i] = casA[i-1];
                    casA[0] = bus.thresh_o[17:0];
                end
                if (bus.thresh_wr_o[1]) begin
                    for (int i = N - 1; i > 0; i--) casB[i] = casB[i-1];
                    casB[0] = bus.thresh_o[35:18];
                end
            end else begin
                check("idle_data_zero", bus.thresh_o, 64'd0);
            end
            if (bus.thresh_update_o[0]) for (int i = 0; i < N; i++) actA[i] = casA[i];
            if (bus.thresh_update_o[1]) for (int i = 0; i < N; i++) actB[i] = casB[i];
        end
    end

    typedef struct {
        logic [1:0]  mask;
        logic [17:0] baseA;
        logic [17:0] baseB;
        logic [1:0]  expWr;
        int          wrFirst;
        int          wrLast;
        int          updC;
        int          doneC;
        int          busyLast;
    } vec_t;
    vec_t vecs [4];

    function automatic logic [5:0] expAt(input logic [1:0] m, input int k);
        logic [1:0] wr, up;
        logic       dn, bz;
        wr = 2'b00; up = 2'b00; dn = 1'b0; bz = 1'b0;
        if (m == 2'b00) begin
            dn = (k == 1);
            bz = (k == 1);
        end else begin
            if (k >= 2 && k <= N + 1) wr = m;
            if (k == N + 2 + D) up = m;
            dn = (k == N + 3 + D);
            bz = (k >= 1 && k <= N + 3 + D);
        end
        return {wr, up, dn, bz};
    endfunction

    function automatic logic [5:0] outVec();
        return {bus.thresh_wr_o, bus.thresh_update_o, bus.done_o, bus.busy_o};
    endfunction

    task automatic hostWrite(input int addr, input logic [17:0] dat);
        bus.thr_wr_i   = 1'b1;
        bus.thr_addr_i = AW'(addr);
        bus.thr_dat_i  = dat;
        if (addr[0]) shB[addr >> 1] = dat;
        else         shA[addr >> 1] = dat;
        @(negedge clk);
        bus.thr_wr_i = 1'b0;
    endtask

    task automatic fillBuf(input logic [17:0] bA, input logic [17:0] bB);
        for (int b = 0; b < N; b++) begin
            hostWrite(2*b,     bA + 18'(b));
            hostWrite(2*b + 1, bB + 18'(b));
        end
    endtask

    task automatic startCommit(input logic [1:0] m);
        bus.commit_i      = 1'b1;
        bus.commit_mask_i = m;
        pushLoad(m);
    endtask

    task automatic checkCycles(input string tag, input vec_t v, input int ncyc);
        logic [5:0] e;
        @(negedge clk);
        bus.commit_i = 1'b0;
        bus.thr_wr_i = 1'b0;
        for (int k = 1; k <= ncyc; k++) begin
            e[5:4] = (k >= v.wrFirst && k <= v.wrLast) ? v.expWr : 2'b00;
            e[3:2] = (k == v.updC) ? v.mask : 2'b00;
            e[1]   = (k == v.doneC);
            e[0]   = (k >= 1 && k <= v.busyLast);
            check($sformatf("%s_cyc%0d", tag, k), {58'd0, outVec()}, {58'd0, e});
            @(negedge clk);
        end
    endtask

    task automatic checkActive(input string tag);
        for (int i = 0; i < N; i++) begin
            check($sformatf("%s_actA%0d", tag, i), {46'd0, actA[i]}, {46'd0, expActA[i]});
            check($sformatf("%s_actB%0d", tag, i), {46'd0, actB[i]}, {46'd0, expActB[i]});
        end
    endtask

    task automatic noteLoaded(input logic [1:0] m);
        for (int i = 0; i < N; i++) begin
            if (m[0]) expActA[i] = shA[i];
            if (m[1]) expActB[i] = shB[i];
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{2'b11, 18'h100, 18'h200, 2'b11, 2,  5, 8, 9, 9};
        vecs[1] = '{2'b01, 18'h110, 18'h210, 2'b01, 2,  5, 8, 9, 9};
        vecs[2] = '{2'b00, 18'h120, 18'h220, 2'b00, 0, -1, 0, 1, 1};
        vecs[3] = '{2'b10, 18'h130, 18'h230, 2'b10, 2,  5, 8, 9, 9};

        for (int i = 0; i < N; i++) begin
            casA[i] = '0; casB[i] = '0; actA[i] = '0; actB[i] = '0;
            expActA[i] = '0; expActB[i] = '0;
        end
        bus.thr_wr_i = 1'b0; bus.thr_addr_i = '0; bus.thr_dat_i = '0;
        bus.commit_i = 1'b0; bus.commit_mask_i = 2'b00;

        repeat (3) @(negedge clk);
        check("rst_thresh", bus.thresh_o, 64'd0);
        check("rst_strobes", {58'd0, outVec()}, 64'd0);
        check("rst_err", {63'd0, bus.err_o}, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Table: the beam-3 lane-A write shares its cycle with the commit.
        foreach (vecs[t]) begin
            for (int b = 0; b < N; b++) begin
                if (b != N - 1) hostWrite(2*b, vecs[t].baseA + 18'(b));
                hostWrite(2*b + 1, vecs[t].baseB + 18'(b));
            end
            bus.thr_wr_i   = 1'b1;
            bus.thr_addr_i = AW'(2*(N-1));
            bus.thr_dat_i  = vecs[t].baseA + 18'(N - 1);
            shA[N-1]       = bus.thr_dat_i;
            startCommit(vecs[t].mask);
            checkCycles($sformatf("vec%0d", t), vecs[t], 11);
            noteLoaded(vecs[t].mask);
            checkActive($sformatf("vec%0d", t));
            check($sformatf("vec%0d_sb_empty", t), 64'(sbq.size()), 64'd0);
        end

        // Host write in cycle 3 of a load is dropped and flags err.
        fillBuf(18'h140, 18'h240);
        startCommit(2'b11);
        @(negedge clk);
        bus.commit_i = 1'b0;
        for (int k = 1; k <= 11; k++) begin
            check($sformatf("wrbusy_cyc%0d", k), {58'd0, outVec()}, {58'd0, expAt(2'b11, k)});
            if (k == 4) check("err_set", {63'd0, bus.err_o}, 64'd1);
            if (k == 3) begin
                bus.thr_wr_i = 1'b1; bus.thr_addr_i = '0; bus.thr_dat_i = 18'h3FFFF;
            end else begin
                bus.thr_wr_i = 1'b0;
            end
            @(negedge clk);
        end
        check("err_sticky", {63'd0, bus.err_o}, 64'd1);
        noteLoaded(2'b11);
        startCommit(2'b01);
        checkCycles("errclr", vecs[1], 11);
        check("err_cleared", {63'd0, bus.err_o}, 64'd0);
        checkActive("wrbusy");

        // Second commit in cycle 4 queues; it starts after one IDLE cycle.
        startCommit(2'b11);
        @(negedge clk);
        bus.commit_i = 1'b0;
        for (int k = 1; k <= 21; k++) begin
            logic [5:0] e;
            e = expAt(2'b11, k) | ((k > 10) ? expAt(2'b10, k - 10) : 6'd0);
            check($sformatf("pend_cyc%0d", k), {58'd0, outVec()}, {58'd0, e});
            if (k == 4) startCommit(2'b10);
            else        bus.commit_i = 1'b0;
            @(negedge clk);
        end
        check("pend_sb_empty", 64'(sbq.size()), 64'd0);
        checkActive("pend");

        // Reset in cycle 3 of a load: outputs drop at once, no update fires.
        fillBuf(18'h150, 18'h250);
        startCommit(2'b11);
        @(negedge clk);
        bus.commit_i = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            check($sformatf("rstload_cyc%0d", k), {58'd0, outVec()}, {58'd0, expAt(2'b11, k)});
            if (k < 3) @(negedge clk);
        end
        #2 rst = 1'b1;
        #1;
        check("rst_async_thresh", bus.thresh_o, 64'd0);
        check("rst_async_strobes", {58'd0, outVec()}, 64'd0);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check($sformatf("rst_hold%0d", k), {58'd0, outVec()}, 64'd0);
        end
        sbq.delete();
        rst = 1'b0;
        @(negedge clk);
        checkActive("rstload");
        startCommit(2'b11);
        checkCycles("rstrec", vecs[0], 11);
        noteLoaded(2'b11);
        checkActive("rstrec");
        check("rstrec_sb_empty", 64'(sbq.size()), 64'd0);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
